spi_bus_arbiter: RTL and testbench

- Shares one SPI master engine among NUM_REQ requesters inside main_6502. Example requesters: ETH (idx 0), DAC (idx 1), ADC (idx 2).
- Arbitration is round-robin, byte-granular, with a transaction lock.
- Per grant, drives the owner's one-hot chip-select and clock-divider setting to the shared master.
- Sequences start/done handshakes and the CS setup/hold guard timing.

---
 rtl/spi_arb_pkg.sv | 42 ++++
 rtl/spi_arb_rr_picker.sv | 22 ++
 rtl/spi_bus_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI bus arbiter: FSM state encoding,
// requester indices and the round-robin grant function.
package spi_arb_pkg;

   localparam int unsigned MAX_REQ = 8;
   localparam int unsigned PTR_W   = 3;
   localparam int unsigned CNT_W   = PTR_W + 1;

   localparam int unsigned REQ_ETH = 0;
   localparam int unsigned REQ_DAC = 1;
   localparam int unsigned REQ_ADC = 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_START = 3'd2,
      ST_WAIT  = 3'd3,
      ST_HOLD  = 3'd4,
      ST_GUARD = 3'd5
   } arb_state_e;

   // First set request at or after ptr, wrapping modulo n; returns one-hot grant.
   function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                  input logic [PTR_W-1:0]   ptr,
                                                  input logic [CNT_W-1:0]   n);
      logic [MAX_REQ-1:0] grant;
      logic               found;
      logic [CNT_W-1:0]   idx;
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < MAX_REQ; i++) begin
         idx = {1'b0, ptr} + CNT_W'(i);
         if (idx >= n) idx = idx - n;
         if (!found && (CNT_W'(i) < n) && req[idx[PTR_W-1:0]]) begin
            grant[idx[PTR_W-1:0]] = 1'b1;
            found = 1'b1;
         end
      end
      return grant;
   endfunction

endpackage

// File: rtl/spi_arb_rr_picker.sv
// Combinational round-robin selector: one-hot grant of the first request
// at or after the priority pointer.
module spi_arb_rr_picker
   import spi_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant_c
);

   logic [MAX_REQ-1:0] grant_full;
   logic               unused_hi;

   always_comb grant_full = rr_pick(MAX_REQ'(req), PTR_W'(ptr), CNT_W'(NUM_REQ));

   assign grant_c   = grant_full[NUM_REQ-1:0];
   assign unused_hi = ^grant_full;

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin, byte-granular arbiter sharing one SPI master with transaction lock.
// Optional HOLD timeout enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_bus_arbiter
   import spi_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ      = 3,
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned DIV_WIDTH    = 8,
   parameter int unsigned GUARD_CYCLES = 2,
   parameter int unsigned HOLD_TIMEOUT = 1024
) (
   input  logic                          clk_i,
   input  logic                          reset_ni,
   input  logic [NUM_REQ-1:0]            req_i,
   input  logic [NUM_REQ-1:0]            last_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] tx_data_i,
   input  logic [NUM_REQ*DIV_WIDTH-1:0]  div_cfg_i,
   output logic [NUM_REQ-1:0]            done_o,
   output logic [DATA_WIDTH-1:0]         rx_data_o,
   output logic [NUM_REQ-1:0]            owner_o,
   output logic                          m_start_o,
   output logic [DATA_WIDTH-1:0]         m_tx_data_o,
   output logic [DIV_WIDTH-1:0]          m_div_o,
   input  logic                          m_busy_i,
   input  logic                          m_done_i,
   input  logic [DATA_WIDTH-1:0]         m_rx_data_i,
   output logic [NUM_REQ-1:0]            cs_no,
   output logic                          timeout_o
);

   localparam int unsigned IDX_W  = $clog2(NUM_REQ);
   localparam int unsigned GCNT_W = 4;

   arb_state_e             state_q, state_d;
   logic [IDX_W-1:0]       owner_q, owner_d;
   logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic                   last_q, last_d;
   logic [GCNT_W-1:0]      gcnt_q, gcnt_d;
   logic [NUM_REQ-1:0]     owner_oh_d, cs_d, done_d;
   logic                   start_d;
   logic [DATA_WIDTH-1:0]  tx_d, rx_d;
   logic [DIV_WIDTH-1:0]   div_d;
   logic [NUM_REQ-1:0]     grant_c;
   logic [IDX_W-1:0]       grant_idx;
   logic [DATA_WIDTH-1:0]  tx_arr  [NUM_REQ];
   logic [DIV_WIDTH-1:0]   div_arr [NUM_REQ];

   spi_arb_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
      .req     (req_i),
      .ptr     (rr_ptr_q),
      .grant_c (grant_c)
   );

   // Unpack per-requester payload buses and encode the one-hot grant.
   always_comb begin
      grant_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         tx_arr[k]  = tx_data_i[k*DATA_WIDTH +: DATA_WIDTH];
         div_arr[k] = div_cfg_i[k*DIV_WIDTH +: DIV_WIDTH];
         if (grant_c[k]) grant_idx = IDX_W'(k);
      end
   end

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int unsigned HCNT_W = $clog2(HOLD_TIMEOUT + 1);
   logic [HCNT_W-1:0] hcnt_q, hcnt_d;
   logic              timeout_d;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         hcnt_q    <= '0;
         timeout_o <= 1'b0;
      end else begin
         hcnt_q    <= hcnt_d;
         timeout_o <= timeout_d;
      end
   end
`else
   logic unused_hold_cfg;
   assign unused_hold_cfg = (HOLD_TIMEOUT != 0);
   assign timeout_o       = 1'b0;
`endif

   // Next-state and next-output logic.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      last_d     = last_q;
      gcnt_d     = gcnt_q;
      owner_oh_d = owner_o;
      cs_d       = cs_no;
      start_d    = 1'b0;
      tx_d       = m_tx_data_o;
      div_d      = m_div_o;
      done_d     = '0;
      rx_d       = rx_data_o;
`ifdef SPI_ARB_TIMEOUT_EN
      hcnt_d     = hcnt_q;
      timeout_d  = timeout_o;
`endif
      case (state_q)
         ST_IDLE: begin
            if (|req_i) begin
               owner_d    = grant_idx;
               owner_oh_d = grant_c;
               cs_d       = ~grant_c;
               tx_d       = tx_arr[grant_idx];
               div_d      = div_arr[grant_idx];
               state_d    = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (!m_busy_i) begin
               start_d = 1'b1;
               last_d  = last_i[owner_q];
               state_d = ST_START;
            end
         end
         ST_START: state_d = ST_WAIT;
         ST_WAIT: begin
            if (m_done_i) begin
               done_d[owner_q] = 1'b1;
               rx_d            = m_rx_data_i;
               if (last_q) begin
                  cs_d       = '1;
                  owner_oh_d = '0;
                  gcnt_d     = '0;
                  state_d    = ST_GUARD;
               end else begin
`ifdef SPI_ARB_TIMEOUT_EN
                  hcnt_d     = '0;
`endif
                  state_d    = ST_HOLD;
               end
            end
         end
         // Lock: only the owner can continue; other requests wait for GUARD.
         ST_HOLD: begin
            if (req_i[owner_q]) begin
               tx_d    = tx_arr[owner_q];
               start_d = 1'b1;
               last_d  = last_i[owner_q];
               state_d = ST_START;
            end
`ifdef SPI_ARB_TIMEOUT_EN
            else if (hcnt_q == HCNT_W'(HOLD_TIMEOUT - 1)) begin
               cs_d       = '1;
               owner_oh_d = '0;
               gcnt_d     = '0;
               timeout_d  = 1'b1;
               state_d    = ST_GUARD;
            end else begin
               hcnt_d = hcnt_q + HCNT_W'(1);
            end
`endif
         end
         ST_GUARD: begin
            if (gcnt_q == GCNT_W'(GUARD_CYCLES - 1)) begin
               rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
               state_d  = ST_IDLE;
            end else begin
               gcnt_d = gcnt_q + GCNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q     <= ST_IDLE;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         last_q      <= 1'b0;
         gcnt_q      <= '0;
         owner_o     <= '0;
         cs_no       <= '1;
         m_start_o   <= 1'b0;
         m_tx_data_o <= '0;
         m_div_o     <= '0;
         done_o      <= '0;
         rx_data_o   <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         last_q      <= last_d;
         gcnt_q      <= gcnt_d;
         owner_o     <= owner_oh_d;
         cs_no       <= cs_d;
         m_start_o   <= start_d;
         m_tx_data_o <= tx_d;
         m_div_o     <= div_d;
         done_o      <= done_d;
         rx_data_o   <= rx_d;
      end
   end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed self-checking bench for spi_bus_arbiter; the HOLD timeout scenario
// follows whether SPI_ARB_TIMEOUT_EN is defined.
module tb_spi_bus_arbiter;
   import spi_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  req, last;
   logic [23:0] tx_data, div_cfg;
   logic [2:0]  done, owner, cs_n;
   logic [7:0]  rx_data, m_tx, m_rx;
   logic [7:0]  m_div;
   logic        m_start, m_busy, m_done, timeout;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   spi_bus_arbiter #(
      .NUM_REQ(3), .DATA_WIDTH(8), .DIV_WIDTH(8), .GUARD_CYCLES(2), .HOLD_TIMEOUT(16)
   ) dut (
      .clk_i       (clk),
      .reset_ni    (rst_n),
      .req_i       (req),
      .last_i      (last),
      .tx_data_i   (tx_data),
      .div_cfg_i   (div_cfg),
      .done_o      (done),
      .rx_data_o   (rx_data),
      .owner_o     (owner),
      .m_start_o   (m_start),
      .m_tx_data_o (m_tx),
      .m_div_o     (m_div),
      .m_busy_i    (m_busy),
      .m_done_i    (m_done),
      .m_rx_data_i (m_rx),
      .cs_no       (cs_n),
      .timeout_o   (timeout)
   );

   // Master stand-in: wait for m_start (bounded), answer after lat cycles.
   // Returns at the negedge where done_o is visible; waits=0 means no start seen.
   task automatic run_byte(input int lat, input logic [7:0] rx, output int waits,
                           output logic [2:0] own, output logic [2:0] cs,
                           output logic [7:0] tx, output logic [7:0] dv);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (m_start !== 1'b1 && n < 50);
      own = owner; cs = cs_n; tx = m_tx; dv = m_div;
      if (m_start !== 1'b1) begin
         waits = 0;
      end else begin
         waits = n;
         repeat (lat - 1) @(negedge clk);
         m_done = 1'b1;
         m_rx   = rx;
         @(negedge clk);
         m_done = 1'b0;
      end
   endtask

   task automatic settle();
      req  = '0;
      last = '0;
      repeat (5) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if ({cs_n, owner, done, m_start} !== {3'b111, 3'b000, 3'b000, 1'b0}) begin
         fails++;
         $display("FAIL reset_ctl: cs=%b owner=%b done=%b start=%b, want 111 000 000 0",
                  cs_n, owner, done, m_start);
      end
      tests++;
      if ({m_tx, m_div, rx_data, timeout} !== 25'h0) begin
         fails++;
         $display("FAIL reset_data: tx=%h div=%h rx=%h timeout=%b, want all 0", m_tx, m_div, rx_data, timeout);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      tests++;
      if (cs_n !== 3'b111 || owner !== 3'b000) begin
         fails++;
         $display("FAIL idle_after_reset: cs=%b owner=%b, want 111 000", cs_n, owner);
      end
   endtask

   task automatic test_single_byte();
      int w, g;
      logic [2:0] own, cs;
      logic [7:0] tx, dv;
      tx_data[REQ_DAC*8 +: 8] = 8'hA5;
      div_cfg[REQ_DAC*8 +: 8] = 8'd10;
      last = 3'b010;
      req  = 3'b010;
      run_byte(20, 8'h3C, w, own, cs, tx, dv);
      tests++;
      if (w !== 2) begin fails++; $display("FAIL single_latency: got %0d cycles, want 2", w); end
      tests++;
      if (tx !== 8'hA5 || dv !== 8'd10) begin
         fails++; $display("FAIL single_tx_div: tx=%h div=%0d, want a5 10", tx, dv);
      end
      tests++;
      if (cs !== 3'b101 || own !== 3'b010) begin
         fails++; $display("FAIL single_cs: cs=%b owner=%b, want 101 010", cs, own);
      end
      tests++;
      if (done !== 3'b010 || rx_data !== 8'h3C) begin
         fails++; $display("FAIL single_done: done=%b rx=%h, want 010 3c", done, rx_data);
      end
      // ETH asks right away; CS must stay high through GUARD (2) plus IDLE (1).
      req  = 3'b001;
      last = 3'b001;
      g = 0;
      while (cs_n === 3'b111 && g < 20) begin
         g++;
         @(negedge clk);
      end
      tests++;
      if (g !== 3) begin fails++; $display("FAIL guard_gap: %0d cycles with cs high, want 3", g); end
      run_byte(4, 8'h01, w, own, cs, tx, dv);
      tests++;
      if (own !== 3'b001 || cs !== 3'b110) begin
         fails++; $display("FAIL after_guard_grant: owner=%b cs=%b, want 001 110", own, cs);
      end
      settle();
   endtask

   task automatic test_round_robin();
      int w;
      logic [2:0] own, cs, exp_own;
      logic [7:0] tx, dv;
      do_reset();
      req  = 3'b111;
      last = 3'b111;
      for (int i = 0; i < 6; i++) begin
         exp_own = 3'b001 << (i % 3);
         run_byte(3, 8'(i), w, own, cs, tx, dv);
         tests++;
         if (own !== exp_own) begin
            fails++; $display("FAIL rr_order[%0d]: owner=%b, want %b", i, own, exp_own);
         end
      end
      settle();
   endtask

   task automatic test_locked_burst();
      int w, dcount;
      logic [2:0] own, cs;
      logic [7:0] tx, dv, exp_rx;
      dcount = 0;
      last = 3'b000;
      tx_data[REQ_ADC*8 +: 8] = 8'h10;
      req  = 3'b100;
      @(negedge clk);
      req  = 3'b101;
      last = 3'b000;
      for (int b = 0; b < 4; b++) begin
         exp_rx = 8'hC0 + 8'(b);
         run_byte(5, exp_rx, w, own, cs, tx, dv);
         tests++;
         if (w !== 1 || own !== 3'b100 || cs !== 3'b011 || tx !== 8'h10 + 8'(b)) begin
            fails++;
            $display("FAIL burst_start[%0d]: wait=%0d owner=%b cs=%b tx=%h, want 1 100 011 %h",
                     b, w, own, cs, tx, 8'h10 + 8'(b));
         end
         if (done === 3'b100 && rx_data === exp_rx) dcount++;
         if (b < 3) begin
            tests++;
            if (cs_n !== 3'b011) begin fails++; $display("FAIL burst_hold_cs[%0d]: cs=%b, want 011", b, cs_n); end
            tx_data[REQ_ADC*8 +: 8] = 8'h10 + 8'(b + 1);
            last = (b == 2) ? 3'b100 : 3'b000;
         end
      end
      tests++;
      if (dcount !== 4) begin fails++; $display("FAIL burst_done_count: %0d, want 4", dcount); end
      tests++;
      if (cs_n !== 3'b111 || owner !== 3'b000) begin
         fails++; $display("FAIL burst_release: cs=%b owner=%b, want 111 000", cs_n, owner);
      end
      req  = 3'b001;
      last = 3'b001;
      run_byte(3, 8'h77, w, own, cs, tx, dv);
      tests++;
      if (own !== 3'b001 || w !== 4) begin
         fails++; $display("FAIL burst_eth_after_guard: owner=%b wait=%0d, want 001 4", own, w);
      end
      settle();
   endtask

   task automatic test_busy_at_grant();
      int w, bad;
      logic [2:0] own, cs;
      logic [7:0] tx, dv;
      bad = 0;
      m_busy = 1'b1;
      tx_data[REQ_DAC*8 +: 8] = 8'h3E;
      req  = 3'b010;
      last = 3'b010;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (cs_n !== 3'b101 || m_start !== 1'b0) bad++;
      end
      tests++;
      if (bad !== 0) begin fails++; $display("FAIL busy_hold: %0d bad cycles, want 0", bad); end
      m_busy = 1'b0;
      run_byte(3, 8'h55, w, own, cs, tx, dv);
      tests++;
      if (w !== 1 || tx !== 8'h3E || cs !== 3'b101) begin
         fails++; $display("FAIL busy_release: wait=%0d tx=%h cs=%b, want 1 3e 101", w, tx, cs);
      end
      settle();
   endtask

   task automatic test_reset_mid_wait();
      int n, w;
      logic [2:0] own, cs;
      logic [7:0] tx, dv;
      req  = 3'b001;
      last = 3'b001;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (m_start !== 1'b1 && n < 50);
      repeat (2) @(negedge clk);
      tests++;
      if (cs_n !== 3'b110) begin fails++; $display("FAIL pre_reset_cs: cs=%b, want 110", cs_n); end
      #2;
      rst_n  = 1'b0;
      m_done = 1'b1;
      #1;
      tests++;
      if (cs_n !== 3'b111 || owner !== 3'b000 || done !== 3'b000 || m_div !== 8'h00) begin
         fails++; $display("FAIL async_reset: cs=%b owner=%b done=%b div=%h, want 111 000 000 00",
                           cs_n, owner, done, m_div);
      end
      @(negedge clk);
      tests++;
      if (done !== 3'b000) begin fails++; $display("FAIL reset_no_done: done=%b, want 000", done); end
      m_done = 1'b0;
      rst_n  = 1'b1;
      req    = 3'b111;
      last   = 3'b111;
      run_byte(3, 8'h99, w, own, cs, tx, dv);
      tests++;
      if (own !== 3'b001) begin fails++; $display("FAIL post_reset_priority: owner=%b, want 001", own); end
      settle();
   endtask

   task automatic test_hold_timeout();
      int w, n;
      logic [2:0] own, cs;
      logic [7:0] tx, dv;
      req  = 3'b001;
      last = 3'b000;
      run_byte(3, 8'h42, w, own, cs, tx, dv);
      tests++;
      if (done !== 3'b001) begin fails++; $display("FAIL timeout_first_done: done=%b, want 001", done); end
      req = 3'b000;
`ifdef SPI_ARB_TIMEOUT_EN
      n = 0;
      while (owner === 3'b001 && n < 200) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (n !== 16 || timeout !== 1'b1 || cs_n !== 3'b111) begin
         fails++; $display("FAIL hold_timeout: released after %0d timeout=%b cs=%b, want 16 1 111", n, timeout, cs_n);
      end
`else
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (owner !== 3'b001 || cs_n !== 3'b110) n++;
      end
      tests++;
      if (n !== 0 || timeout !== 1'b0) begin
         fails++; $display("FAIL hold_no_timeout: %0d cycles out of HOLD timeout=%b, want 0 0", n, timeout);
      end
`endif
      do_reset();
   endtask

   initial begin
      rst_n = 1'b0; req = '0; last = '0; tx_data = '0; div_cfg = '0;
      m_busy = 1'b0; m_done = 1'b0; m_rx = '0;
      test_reset();
      test_single_byte();
      test_round_robin();
      test_locked_burst();
      test_busy_at_grant();
      test_reset_mid_wait();
      test_hold_timeout();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
